// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku group pruner and the cells it sequences.
//   state_t  : pruner sequencing states
//   NCELLS   : cells per constraint group
//   DIGIT_W  : width of a cell value / candidate mask (bit k = digit k)
//   ADDR_*   : cell register addresses on the shared group bus
//   onehot9  : true when a 9-bit value has exactly one bit set
package sudoku_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        TURN,
        WRITE,
        DONE
    } state_t;

    localparam int   NCELLS     = 9;
    localparam int   DIGIT_W    = 9;
    localparam logic ADDR_VALUE = 1'b0;
    localparam logic ADDR_VALID = 1'b1;

    function automatic logic onehot9(input logic [DIGIT_W-1:0] v);
        return (v != '0) && ((v & (v - 9'd1)) == '0);
    endfunction

endpackage

// File: rtl/sudoku_onehot_dec.sv
// Cell-select decoder: turns a cell index (0..8) into a one-hot enable.
// Indices outside 0..8 decode to all zeros.
//   idx    : cell index
//   onehot : bit i set when idx == i
module sudoku_onehot_dec
    import sudoku_pkg::*;
(
    input  logic [3:0]        idx,
    output logic [NCELLS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NCELLS; i++) begin
            onehot[i] = (idx == 4'(i));
        end
    end

endmodule

// File: rtl/sudoku_group_pruner.sv
// Prunes the candidates of one Sudoku group (row, column or box).
// Reads each of the nine cells' solved values over the shared bus, ORs them
// into a used-digit mask, then writes ~mask into every cell's candidate
// register. Optional conflict detection: define SUDOKU_CONFLICT_DETECT_EN.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a pass (only looked at while idle)
//   busy       : pass in progress
//   done       : one-cycle pulse at pass end
//   used_mask  : OR of all cell values from the last pass
//   cell_addr  : 0 = value register, 1 = candidate register
//   cell_oe    : one-hot cell read enable
//   cell_we    : one-hot cell write enable
//   value_io   : shared group bus, driven here only while writing
//   conflict   : (optional) duplicate or malformed value seen, valid with done
module sudoku_group_pruner
    import sudoku_pkg::*;
#(
    parameter int TURN_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] used_mask,
    output logic               cell_addr,
    output logic [NCELLS-1:0]  cell_oe,
    output logic [NCELLS-1:0]  cell_we,
    inout  wire  [DIGIT_W-1:0] value_io
`ifdef SUDOKU_CONFLICT_DETECT_EN
    ,
    output logic               conflict
`endif
);

    state_t             state_q, state_n;
    logic [3:0]         idx_q, idx_n;
    logic [DIGIT_W-1:0] acc_q, acc_n;
    logic               busy_n, done_n;
    logic [DIGIT_W-1:0] mask_n;
    logic               drive_q;
    logic [NCELLS-1:0]  sel_n;
    logic               skip_write;
`ifdef SUDOKU_CONFLICT_DETECT_EN
    logic               conf_n;
`endif

    // The bus is only ours while writing; ~acc is stable for the whole phase.
    assign value_io = drive_q ? ~acc_q : 'z;

    // Enables are decoded from the next index so they come straight off flops.
    sudoku_onehot_dec u_dec (
        .idx    (idx_n),
        .onehot (sel_n)
    );

    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        acc_n      = acc_q;
        busy_n     = busy;
        done_n     = 1'b0;
        mask_n     = used_mask;
        skip_write = 1'b0;
`ifdef SUDOKU_CONFLICT_DETECT_EN
        conf_n     = conflict;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = READ;
                    idx_n   = '0;
                    acc_n   = '0;
                    busy_n  = 1'b1;
`ifdef SUDOKU_CONFLICT_DETECT_EN
                    conf_n  = 1'b0;
`endif
                end
            end
            READ: begin
                acc_n = acc_q | value_io;
`ifdef SUDOKU_CONFLICT_DETECT_EN
                // Digit already seen in this group, or a malformed value.
                conf_n = conflict | ((value_io & acc_q) != '0)
                       | ((value_io != '0) && !onehot9(value_io));
                skip_write = conf_n;
`endif
                if (idx_q == 4'(NCELLS-1)) begin
                    idx_n = '0;
                    if (skip_write) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        mask_n  = acc_n;
                    end else if (TURN_CYCLES == 0) begin
                        state_n = WRITE;
                    end else begin
                        state_n = TURN;
                    end
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end
            TURN: begin
                // idx doubles as the turnaround counter.
                if (idx_q == 4'(TURN_CYCLES-1)) begin
                    state_n = WRITE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end
            WRITE: begin
                if (idx_q == 4'(NCELLS-1)) begin
                    state_n = DONE;
                    idx_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    mask_n  = acc_q;
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            used_mask <= '0;
            cell_addr <= ADDR_VALUE;
            cell_oe   <= '0;
            cell_we   <= '0;
            drive_q   <= 1'b0;
`ifdef SUDOKU_CONFLICT_DETECT_EN
            conflict  <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            acc_q     <= acc_n;
            busy      <= busy_n;
            done      <= done_n;
            used_mask <= mask_n;
            cell_addr <= (state_n == WRITE) ? ADDR_VALID : ADDR_VALUE;
            cell_oe   <= (state_n == READ)  ? sel_n : '0;
            cell_we   <= (state_n == WRITE) ? sel_n : '0;
            drive_q   <= (state_n == WRITE);
`ifdef SUDOKU_CONFLICT_DETECT_EN
            conflict  <= conf_n;
`endif
        end
    end

endmodule

// File: tb/tb_sudoku_group_pruner.sv
// Bench for sudoku_group_pruner: two instances (TURN_CYCLES 0 and 2) share
// start/reset and see identical cell contents; each has its own nine-cell
// model on its own bus. Expectations come from the group rules: used mask is
// the OR of the values, unsolved cells end with ~mask, solved cells with 0.
module tb_sudoku_group_pruner;

    logic clk, reset, start, load;
    logic [8:0][8:0] cval;
    logic [8:0][8:0] cvalid0, cvalid1;

    logic busy0, done0, addr0, busy1, done1, addr1;
    logic [8:0] mask0, oe0, we0, mask1, oe1, we1;
    wire  [8:0] vio0, vio1;
`ifdef SUDOKU_CONFLICT_DETECT_EN
    logic conflict0, conflict1;
`endif

    int checks = 0;
    int failures = 0;

    sudoku_group_pruner #(.TURN_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
        .used_mask(mask0), .cell_addr(addr0), .cell_oe(oe0), .cell_we(we0),
        .value_io(vio0)
`ifdef SUDOKU_CONFLICT_DETECT_EN
        , .conflict(conflict0)
`endif
    );

    sudoku_group_pruner #(.TURN_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .used_mask(mask1), .cell_addr(addr1), .cell_oe(oe1), .cell_we(we1),
        .value_io(vio1)
`ifdef SUDOKU_CONFLICT_DETECT_EN
        , .conflict(conflict1)
`endif
    );

    // ---- cell models ----
    function automatic logic [8:0] cell_out(input logic [8:0] oe, input logic a,
                                            input logic [8:0][8:0] v,
                                            input logic [8:0][8:0] vl);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) if (oe[i]) r |= a ? vl[i] : v[i];
        return r;
    endfunction

    assign vio0 = (oe0 != '0) ? cell_out(oe0, addr0, cval, cvalid0) : 9'bz;
    assign vio1 = (oe1 != '0) ? cell_out(oe1, addr1, cval, cvalid1) : 9'bz;

    // Cells share the system reset, which blocks writes in that cycle.
    always @(posedge clk) begin
        if (load) cvalid0 <= {9{9'h1FF}};
        else if (!reset && addr0)
            for (int i = 0; i < 9; i++)
                if (we0[i]) cvalid0[i] <= (cval[i] != '0) ? 9'h0 : (cvalid0[i] & vio0);
    end

    always @(posedge clk) begin
        if (load) cvalid1 <= {9{9'h1FF}};
        else if (!reset && addr1)
            for (int i = 0; i < 9; i++)
                if (we1[i]) cvalid1[i] <= (cval[i] != '0) ? 9'h0 : (cvalid1[i] & vio1);
    end

    // ---- per-instance views ----
    logic [8:0] oe_a[2], we_a[2], vio_a[2], mask_a[2];
    logic       busy_a[2], done_a[2], addr_a[2], conf_a[2];
    assign oe_a[0] = oe0;    assign oe_a[1] = oe1;
    assign we_a[0] = we0;    assign we_a[1] = we1;
    assign vio_a[0] = vio0;  assign vio_a[1] = vio1;
    assign mask_a[0] = mask0; assign mask_a[1] = mask1;
    assign busy_a[0] = busy0; assign busy_a[1] = busy1;
    assign done_a[0] = done0; assign done_a[1] = done1;
    assign addr_a[0] = addr0; assign addr_a[1] = addr1;
`ifdef SUDOKU_CONFLICT_DETECT_EN
    assign conf_a[0] = conflict0; assign conf_a[1] = conflict1;
`else
    assign conf_a[0] = 1'b0; assign conf_a[1] = 1'b0;
`endif

    function automatic logic [8:0] valid_of(input int k, input int i);
        return (k == 0) ? cvalid0[i] : cvalid1[i];
    endfunction

    function automatic int tc(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic logic [8:0] model_mask(input logic [8:0][8:0] v);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) m |= v[i];
        return m;
    endfunction

    // A digit claimed by two cells, or a cell claiming several digits.
    function automatic bit model_conflict(input logic [8:0][8:0] v);
`ifdef SUDOKU_CONFLICT_DETECT_EN
        for (int d = 0; d < 9; d++) begin
            int n;
            n = 0;
            for (int i = 0; i < 9; i++) n += int'(v[i][d]);
            if (n > 1) return 1'b1;
        end
        for (int i = 0; i < 9; i++) if ($countones(v[i]) > 1) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic load_cells(input logic [8:0][8:0] v);
        cval = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // One pass on both instances. extra_start re-pulses start at cycle 5;
    // rst_at > 0 asserts reset during that cycle.
    task automatic run_pass(input bit extra_start, input int rst_at);
        int done_cyc[2], ndone[2], oecnt[2], wecnt[2], oe8[2], w0[2], viol[2], badw[2];
        logic busy1st[2], busy_done[2];
        logic [8:0] m, ev;
        bit conf;
        int wn;
        m = model_mask(cval);
        conf = model_conflict(cval);
        for (int k = 0; k < 2; k++) begin
            done_cyc[k] = -1; ndone[k] = 0; oecnt[k] = 0; wecnt[k] = 0;
            oe8[k] = -1; w0[k] = -1; viol[k] = 0; badw[k] = 0;
            busy1st[k] = 1'b0; busy_done[k] = 1'b1;
        end
        start = 1'b1;
        step();
        for (int c = 1; c <= 30; c++) begin
            start = (extra_start && c == 5);
            if (rst_at > 0 && c == rst_at) reset = 1'b1;
            if (rst_at > 0 && c == rst_at + 1) begin
                for (int k = 0; k < 2; k++) begin
                    chk("rst_oe", k, 32'(oe_a[k]), 32'h0);
                    chk("rst_we", k, 32'(we_a[k]), 32'h0);
                    chk("rst_busy", k, 32'(busy_a[k]), 32'h0);
                    chk("rst_mask", k, 32'(mask_a[k]), 32'h0);
                end
                reset = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (oe_a[k] != '0 && we_a[k] != '0) viol[k]++;
                if ($countones(oe_a[k] | we_a[k]) > 1) viol[k]++;
                if (oe_a[k] != '0) oecnt[k]++;
                if (we_a[k] != '0) wecnt[k]++;
                if (oe_a[k][8]) oe8[k] = c;
                if (we_a[k][0] && w0[k] < 0) w0[k] = c;
                if (we_a[k] != '0 && vio_a[k] !== ~m) badw[k]++;
                if (c == 1) busy1st[k] = busy_a[k];
                if (done_a[k]) begin
                    ndone[k]++;
                    done_cyc[k] = c;
                    busy_done[k] = busy_a[k];
                end
            end
            step();
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("bus_rule", k, 32'(viol[k]), 32'h0);
            if (rst_at > 0) begin
                chk("rst_ndone", k, 32'(ndone[k]), 32'h0);
                wn = rst_at - (10 + tc(k));
                for (int i = 0; i < 9; i++) begin
                    ev = (i < wn) ? ((cval[i] != '0) ? 9'h0 : ~m) : 9'h1FF;
                    chk("rst_valid", k * 10 + i, 32'(valid_of(k, i)), 32'(ev));
                end
            end else begin
                chk("busy_c1", k, 32'(busy1st[k]), 32'h1);
                chk("done_cycle", k, 32'(done_cyc[k]), conf ? 32'd10 : 32'(19 + tc(k)));
                chk("ndone", k, 32'(ndone[k]), 32'h1);
                chk("busy_at_done", k, 32'(busy_done[k]), 32'h0);
                chk("used_mask", k, 32'(mask_a[k]), 32'(m));
                chk("oe_cycles", k, 32'(oecnt[k]), 32'd9);
                chk("we_cycles", k, 32'(wecnt[k]), conf ? 32'd0 : 32'd9);
                chk("write_data", k, 32'(badw[k]), 32'h0);
                if (!conf) chk("turn_gap", k, 32'(w0[k] - oe8[k]), 32'(tc(k) + 1));
`ifdef SUDOKU_CONFLICT_DETECT_EN
                chk("conflict", k, 32'(conf_a[k]), 32'(conf));
`endif
                for (int i = 0; i < 9; i++) begin
                    ev = conf ? 9'h1FF : ((cval[i] != '0) ? 9'h0 : ~m);
                    chk("valid", k * 10 + i, 32'(valid_of(k, i)), 32'(ev));
                end
            end
        end
    endtask

    initial begin : main
        logic [8:0][8:0] v;
        reset = 1'b1; start = 1'b0; load = 1'b1; cval = '0;
        step(); step();
        reset = 1'b0; load = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", k, 32'(busy_a[k]), 32'h0);
            chk("reset_done", k, 32'(done_a[k]), 32'h0);
            chk("reset_mask", k, 32'(mask_a[k]), 32'h0);
            chk("reset_oe", k, 32'(oe_a[k]), 32'h0);
            chk("reset_we", k, 32'(we_a[k]), 32'h0);
            chk("reset_addr", k, 32'(addr_a[k]), 32'h0);
            chk("reset_conf", k, 32'(conf_a[k]), 32'h0);
        end

        // Digits 1, 5, 9 solved in cells 0, 4, 8.
        v = '0; v[0] = 9'h001; v[4] = 9'h010; v[8] = 9'h100;
        load_cells(v);
        run_pass(1'b0, 0);

        // Nothing solved; second start while busy must be ignored.
        v = '0;
        load_cells(v);
        run_pass(1'b1, 0);

        // Reset in the middle of the write phase.
        v = '0; v[0] = 9'h001; v[4] = 9'h010; v[8] = 9'h100;
        load_cells(v);
        run_pass(1'b0, 13);

        // Random groups, including unsolved, duplicate and malformed values.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: v[i] = 9'h0;
                    3, 4:    v[i] = 9'h1 << $urandom_range(0, 8);
                    default: v[i] = 9'($urandom);
                endcase
            end
            load_cells(v);
            run_pass(1'b0, 0);
        end

`ifdef SUDOKU_CONFLICT_DETECT_EN
        // Digit 3 claimed twice: pass ends early, nothing written.
        v = '0; v[1] = 9'h004; v[5] = 9'h004;
        load_cells(v);
        run_pass(1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sudoku_group_pruner.md
Name: sudoku_group_pruner

Overview:
- Sequences one Sudoku constraint group (row, column or box) of nine cell instances over their shared 9-bit value bus.
- Reads every cell's solved value (address 0) and ORs them into a used-digit mask.
- Writes the complement of that mask to every cell's candidate register (address 1), pruning candidates.
- Sits directly upstream of the cells; a top-level solver FSM starts one pruner per group and later pulses latch_singleton on the cells.

Parameters:
- TURN_CYCLES, 0: idle cycles inserted between the read phase and the write phase for bus turnaround (0..3).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin one prune pass; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse when the pass completes
- used_mask  output  9  OR of all cell values from the last pass; bit k = digit k
- cell_addr  output  1  address to all nine cells: 0 = value, 1 = valid
- cell_oe  output  9  one-hot output enable, bit i = cell i
- cell_we  output  9  one-hot write enable, bit i = cell i
- value_io  inout  9  shared group bus; driven by this block only while writing

Behaviour:
- Reset: state IDLE; busy=0, done=0, used_mask=0, cell_oe=0, cell_we=0, cell_addr=0, value_io released (high-Z); internal index and accumulator cleared.
- IDLE: start=1 loads idx=0 and acc=0, then enters READ. start while busy is ignored; no queueing.
- READ, one cycle per cell, idx 0..8:
  - cell_addr=0, cell_oe[idx]=1, block does not drive the bus.
  - acc |= value_io is sampled at the posedge.
  - idx 8 leads to TURN, or to WRITE when TURN_CYCLES=0.
- TURN: all enables low, bus released, for TURN_CYCLES cycles.
- WRITE, one cycle per cell, idx 0..8:
  - cell_addr=1, cell_we[idx]=1, block drives value_io = ~acc.
  - Each cell ANDs this into its valid register; already-solved cells clear valid themselves.
  - idx 8 leads to DONE.
- DONE: one cycle. done=1, used_mask<=acc, enables low, then IDLE. busy drops in the same cycle done rises.
- Latency: start asserted at cycle 0 gives done high at cycle 19+TURN_CYCLES.
- Bus rules:
  - At most one bit of cell_oe | cell_we is set in any cycle.
  - cell_oe and cell_we are never both non-zero.
  - The block drives value_io only in WRITE.
- Unsolved cells read as 0, which contributes nothing to acc.
- A cell value that is not one-hot (e.g. 9'b000000011) is ORed as-is; there is no error unless the optional feature is compiled in.
- Reset mid-pass: enables drop and the bus is released on the next edge. Cells already written keep their pruned valid. used_mask returns to 0.
- All outputs are registered; no combinational path from value_io to any output.

Optional Feature:
- Macro SUDOKU_CONFLICT_DETECT_EN.
- With it defined:
  - Adds output port conflict (1 bit).
  - During READ, if (value_io & acc) != 0, or value_io is non-zero and not one-hot, a sticky conflict flag is set.
  - At the end of READ a set flag skips TURN/WRITE and goes straight to DONE, so no cell is written.
  - conflict is valid with done, held until the next accepted start, and reset to 0.
- Without it: no conflict port; duplicates are ORed and the write phase always runs.

Decomposition:
- Shared package sudoku_pkg:
  - state encoding constants: IDLE, READ, TURN, WRITE, DONE
  - constants: NCELLS = 9, DIGIT_W = 9, ADDR_VALUE = 0, ADDR_VALID = 1
  - a onehot9 check function, also usable by the cells
- One sub-module is natural: sudoku_onehot_dec, which converts 4-bit idx to the 9-bit one-hot enable; it is shared by cell_oe and cell_we.
- No further hierarchy.

Test Plan:
- Cells preloaded with values 1, 5, 9 and the rest 0, TURN_CYCLES=0; pulse start -> done at cycle 19; used_mask=9'h111; each unsolved cell's valid reads 9'h0EE; solved cells' valid = 0.
- All nine cells unsolved; pulse start -> used_mask=0; every valid stays 9'h1FF.
- Assert start again while busy at cycle 5 -> ignored; exactly one done pulse at cycle 19.
- Reset asserted at cycle 13 (mid-WRITE) -> next cycle all enables 0, value_io is Z, busy=0; cells 0..2 show pruned valid, cells 3..8 keep 9'h1FF.
- TURN_CYCLES=2 -> two cycles with all enables low between cell_oe[8] and cell_we[0]; done at cycle 21.
- With SUDOKU_CONFLICT_DETECT_EN, cells hold 9'h004 twice -> conflict=1 with done at cycle 10; cell_we never asserts; valids unchanged.
